sfifo_mch_enc: RTL and testbench

- CH_NUM independent synchronous FIFOs behind one flattened interface. Each channel has even-parity protection, run-time programmable almost-full/almost-empty thresholds with hysteresis, sticky error status and a peak-occupancy watermark.
- Replaces per-channel single FIFO instances in multi-queue datapaths such as DMA descriptor and completion queues.

---
 rtl/sfifo_mch_enc.sv | 229 ++++++++++++++++++++++
 tb/tb_sfifo_mch_enc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_mch_enc.sv
// ---------------------------------------------------------------------------
// sfifo_mch_enc
//
// CH_NUM independent synchronous FIFOs behind one flattened interface.
// Each channel has:
//   - optional even-parity protection per entry, with an error-injection input
//   - run-time programmable almost-full (with hysteresis) and almost-empty flags
//   - sticky overflow / underflow / parity status
//   - a peak-occupancy watermark
// The channels share only the clock and reset; there is no arbitration.
//
// Ports (channel c always uses slice c of each bus):
//   clk_sys     in   system clock
//   reset_n     in   synchronous reset, active low
//   wen         in   [CH_NUM]               write enable
//   wdata       in   [CH_NUM*FIFO_WIDTH]    write data
//   err_inj     in   [CH_NUM]               invert stored parity of this cycle's write
//   ren         in   [CH_NUM]               read enable
//   rdata       out  [CH_NUM*FIFO_WIDTH]    read data
//   afull_thd   in   [CH_NUM*(FIFO_DEEP+1)] almost-full set threshold
//   aempty_thd  in   [CH_NUM*(FIFO_DEEP+1)] almost-empty threshold
//   stat_clr    in   [CH_NUM]               clear sticky status and watermark
//   full        out  [CH_NUM]               used == depth (combinational)
//   empty       out  [CH_NUM]               used == 0 (combinational)
//   afull       out  [CH_NUM]               registered almost-full
//   aempty      out  [CH_NUM]               registered almost-empty
//   usedw       out  [CH_NUM*(FIFO_DEEP+1)] occupancy
//   max_used    out  [CH_NUM*(FIFO_DEEP+1)] peak occupancy
//   parity_err  out  [CH_NUM]               parity error aligned with rdata
//   fifo_stat   out  [CH_NUM*8]             {rsv, parity_sticky, overflow,
//                                            underflow, afull, full,
//                                            ~aempty, ~empty}
// ---------------------------------------------------------------------------
module sfifo_mch_enc #(
    parameter int    CH_NUM      = 4,
    parameter int    FIFO_WIDTH  = 8,
    parameter int    FIFO_DEEP   = 4,
    parameter string FIFO_PARITY = "TRUE",
    parameter string FIFO_ATTR   = "normal",
    parameter int    AFULL_HYST  = 2
) (
    input  logic                              clk_sys,
    input  logic                              reset_n,
    input  logic [CH_NUM-1:0]                 wen,
    input  logic [CH_NUM*FIFO_WIDTH-1:0]      wdata,
    input  logic [CH_NUM-1:0]                 err_inj,
    input  logic [CH_NUM-1:0]                 ren,
    output logic [CH_NUM*FIFO_WIDTH-1:0]      rdata,
    input  logic [CH_NUM*(FIFO_DEEP+1)-1:0]   afull_thd,
    input  logic [CH_NUM*(FIFO_DEEP+1)-1:0]   aempty_thd,
    input  logic [CH_NUM-1:0]                 stat_clr,
    output logic [CH_NUM-1:0]                 full,
    output logic [CH_NUM-1:0]                 empty,
    output logic [CH_NUM-1:0]                 afull,
    output logic [CH_NUM-1:0]                 aempty,
    output logic [CH_NUM*(FIFO_DEEP+1)-1:0]   usedw,
    output logic [CH_NUM*(FIFO_DEEP+1)-1:0]   max_used,
    output logic [CH_NUM-1:0]                 parity_err,
    output logic [CH_NUM*8-1:0]               fifo_stat
);

    localparam int DW    = FIFO_DEEP + 1;
    localparam int DEPTH = 2 ** FIFO_DEEP;
    localparam int MW    = FIFO_WIDTH + 1;   // stored entry: {parity, data}

    localparam bit PAR_EN = (FIFO_PARITY == "TRUE");
    localparam bit AHEAD  = (FIFO_ATTR == "ahead");

    // Parity bit to store with an entry. With parity disabled the bit is a
    // constant 0 and the storage column is trimmed away by synthesis.
    function automatic logic parity_gen(input logic [FIFO_WIDTH-1:0] d,
                                        input logic inj);
        if (!PAR_EN)
            return 1'b0;
        return (^d) ^ inj;
    endfunction

    // Even parity over {parity, data} must be 0 for a good entry.
    function automatic logic parity_bad(input logic [MW-1:0] e);
        if (!PAR_EN)
            return 1'b0;
        return ^e;
    endfunction

    // Almost-full with hysteresis: set at/above the threshold, clear only
    // below (threshold - AFULL_HYST) floored at zero, otherwise hold.
    // A threshold of 0 therefore keeps the flag permanently set.
    function automatic logic afull_eval(input logic [DW-1:0] u,
                                        input logic [DW-1:0] thd,
                                        input logic          cur);
        logic [DW-1:0] lvl;
        lvl = (thd > DW'(AFULL_HYST)) ? (thd - DW'(AFULL_HYST)) : '0;
        if (u >= thd)
            return 1'b1;
        if (u < lvl)
            return 1'b0;
        return cur;
    endfunction

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch

        logic [MW-1:0]         mem [DEPTH];
        logic [FIFO_DEEP-1:0]  wptr;
        logic [FIFO_DEEP-1:0]  rptr;
        logic [DW-1:0]         used;
        logic [DW-1:0]         used_next;
        logic [DW-1:0]         max_q;
        logic [DW-1:0]         max_base;
        logic [DW-1:0]         athd;
        logic [DW-1:0]         ethd;
        logic [FIFO_WIDTH-1:0] wd;
        logic [MW-1:0]         head;
        logic [FIFO_WIDTH-1:0] rd_out;

        logic full_c;
        logic empty_c;
        logic wr_acc;
        logic rd_acc;
        logic ovf_ev;
        logic udf_ev;
        logic par_ev;
        logic perr_out;
        logic head_bad;

        logic afull_q;
        logic aempty_q;
        logic ovf_q;
        logic udf_q;
        logic par_q;

        assign wd   = wdata[c*FIFO_WIDTH +: FIFO_WIDTH];
        assign athd = afull_thd[c*DW +: DW];
        assign ethd = aempty_thd[c*DW +: DW];

        assign full_c  = (used == DW'(DEPTH));
        assign empty_c = (used == '0);

        // A write into a full channel is still accepted when a read frees
        // a slot in the same cycle. A read of an empty channel is never
        // accepted, even if a write lands in that cycle.
        assign wr_acc = wen[c] & (~full_c | ren[c]);
        assign rd_acc = ren[c] & ~empty_c;
        assign ovf_ev = wen[c] & full_c & ~ren[c];
        assign udf_ev = ren[c] & empty_c;

        assign used_next = used + DW'(wr_acc) - DW'(rd_acc);

        assign head     = mem[rptr];
        assign head_bad = parity_bad(head);

        // Watermark restarts from the current occupancy on stat_clr; an
        // increase in the same cycle still gets recorded.
        assign max_base = stat_clr[c] ? used : max_q;

        // ---- storage write (data path, not reset) ----
        always_ff @(posedge clk_sys) begin
            if (reset_n && wr_acc)
                mem[wptr] <= {parity_gen(wd, err_inj[c]), wd};
        end

        // ---- control state: pointers, occupancy, flags, status ----
        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                wptr     <= '0;
                rptr     <= '0;
                used     <= '0;
                max_q    <= '0;
                afull_q  <= 1'b0;
                aempty_q <= 1'b1;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
                par_q    <= 1'b0;
            end else begin
                if (wr_acc)
                    wptr <= wptr + 1'b1;
                if (rd_acc)
                    rptr <= rptr + 1'b1;
                used     <= used_next;
                max_q    <= (used_next > max_base) ? used_next : max_base;
                afull_q  <= afull_eval(used_next, athd, afull_q);
                aempty_q <= (used_next <= ethd);
                ovf_q    <= ovf_ev | (ovf_q & ~stat_clr[c]);
                udf_q    <= udf_ev | (udf_q & ~stat_clr[c]);
                par_q    <= par_ev | (par_q & ~stat_clr[c]);
            end
        end

        if (AHEAD) begin : g_ahead
            // First-word fall-through: the head entry is shown directly.
            // An empty channel shows 0 so stale memory never leaks out.
            assign rd_out   = empty_c ? '0 : head[FIFO_WIDTH-1:0];
            assign perr_out = ~empty_c & head_bad;
            assign par_ev   = perr_out;
        end else begin : g_normal
            logic [FIFO_WIDTH-1:0] rdata_p1;
            logic                  perr_p1;

            // Sticky parity rises together with the rdata/parity_err pulse.
            assign par_ev = rd_acc & head_bad;

            // ---- read register stage: rdata valid the cycle after ren ----
            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    rdata_p1 <= '0;
                    perr_p1  <= 1'b0;
                end else begin
                    if (rd_acc)
                        rdata_p1 <= head[FIFO_WIDTH-1:0];
                    perr_p1 <= par_ev;
                end
            end

            assign rd_out   = rdata_p1;
            assign perr_out = perr_p1;
        end

        assign rdata[c*FIFO_WIDTH +: FIFO_WIDTH] = rd_out;
        assign full[c]                           = full_c;
        assign empty[c]                          = empty_c;
        assign afull[c]                          = afull_q;
        assign aempty[c]                         = aempty_q;
        assign usedw[c*DW +: DW]                 = used;
        assign max_used[c*DW +: DW]              = max_q;
        assign parity_err[c]                     = perr_out;
        assign fifo_stat[c*8 +: 8] = {1'b0, par_q, ovf_q, udf_q,
                                      afull_q, full_c, ~aempty_q, ~empty_c};
    end

endmodule

// File: tb/tb_sfifo_mch_enc.sv
// ---------------------------------------------------------------------------
// tb_sfifo_mch_enc
//
// Directed bench for sfifo_mch_enc. Two instances share the stimulus: one in
// "normal" (registered read) mode and one in "ahead" (fall-through) mode.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_sfifo_mch_enc;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [3:0]  wen, err_inj, ren, stat_clr;
    logic [31:0] wdata;
    logic [19:0] afull_thd, aempty_thd;

    logic [31:0] rdata_n, rdata_a, fifo_stat_n, fifo_stat_a;
    logic [3:0]  full_n, empty_n, afull_n, aempty_n, perr_n;
    logic [3:0]  full_a, empty_a, afull_a, aempty_a, perr_a;
    logic [19:0] usedw_n, max_n, usedw_a, max_a;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    sfifo_mch_enc #(.FIFO_ATTR("normal")) dut_n (
        .clk_sys(clk_sys), .reset_n(reset_n), .wen(wen), .wdata(wdata),
        .err_inj(err_inj), .ren(ren), .rdata(rdata_n),
        .afull_thd(afull_thd), .aempty_thd(aempty_thd), .stat_clr(stat_clr),
        .full(full_n), .empty(empty_n), .afull(afull_n), .aempty(aempty_n),
        .usedw(usedw_n), .max_used(max_n), .parity_err(perr_n),
        .fifo_stat(fifo_stat_n)
    );

    sfifo_mch_enc #(.FIFO_ATTR("ahead")) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .wen(wen), .wdata(wdata),
        .err_inj(err_inj), .ren(ren), .rdata(rdata_a),
        .afull_thd(afull_thd), .aempty_thd(aempty_thd), .stat_clr(stat_clr),
        .full(full_a), .empty(empty_a), .afull(afull_a), .aempty(aempty_a),
        .usedw(usedw_a), .max_used(max_a), .parity_err(perr_a),
        .fifo_stat(fifo_stat_a)
    );

    function automatic logic [7:0] b8(input logic [31:0] v, input int c);
        return v[c*8 +: 8];
    endfunction

    function automatic logic [4:0] u5(input logic [19:0] v, input int c);
        return v[c*5 +: 5];
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic put(input int c, input logic [7:0] v);
        wdata        = '0;
        wdata[c*8 +: 8] = v;
        wen          = 4'b0001 << c;
    endtask

    task automatic idle();
        wen = '0; ren = '0; err_inj = '0; stat_clr = '0; wdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        step(); step();
        checks++; if (empty_n !== 4'hF) begin errors++; $display("FAIL reset_empty got=%h exp=F", empty_n); end
        checks++; if (full_n !== 4'h0) begin errors++; $display("FAIL reset_full got=%h exp=0", full_n); end
        checks++; if (aempty_n !== 4'hF || afull_n !== 4'h0) begin errors++; $display("FAIL reset_aflags aempty=%h afull=%h exp F/0", aempty_n, afull_n); end
        checks++; if (usedw_n !== 20'h0 || max_n !== 20'h0) begin errors++; $display("FAIL reset_used usedw=%h max=%h exp 0", usedw_n, max_n); end
        checks++; if (rdata_n !== 32'h0 || rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata n=%h a=%h exp 0", rdata_n, rdata_a); end
        checks++; if (fifo_stat_n !== 32'h0 || perr_n !== 4'h0) begin errors++; $display("FAIL reset_stat stat=%h perr=%h exp 0", fifo_stat_n, perr_n); end
        reset_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            put(1, 8'(i));
            step();
        end
        idle();
        checks++; if (full_n !== 4'b0010) begin errors++; $display("FAIL fill_full got=%b exp=0010", full_n); end
        checks++; if (u5(usedw_n, 1) !== 5'd16) begin errors++; $display("FAIL fill_usedw got=%0d exp=16", u5(usedw_n, 1)); end
        checks++; if (u5(max_n, 1) !== 5'd16) begin errors++; $display("FAIL fill_max got=%0d exp=16", u5(max_n, 1)); end
        checks++; if (empty_n !== 4'b1101) begin errors++; $display("FAIL fill_others_empty got=%b exp=1101", empty_n); end
        checks++; if (b8(fifo_stat_n, 1) !== 8'h0F) begin errors++; $display("FAIL fill_stat got=%h exp=0F", b8(fifo_stat_n, 1)); end
        checks++; if (b8(rdata_a, 1) !== 8'h00) begin errors++; $display("FAIL fill_ahead_head got=%h exp=00", b8(rdata_a, 1)); end
        for (int i = 0; i < 16; i++) begin
            ren = 4'b0010;
            step();
            checks++; if (b8(rdata_n, 1) !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, b8(rdata_n, 1), 8'(i)); end
        end
        idle();
        step();
        checks++; if (b8(rdata_n, 1) !== 8'h0F) begin errors++; $display("FAIL drain_hold got=%h exp=0F", b8(rdata_n, 1)); end
        checks++; if (empty_n[1] !== 1'b1 || u5(max_n, 1) !== 5'd16) begin errors++; $display("FAIL drain_empty empty=%b max=%0d exp 1/16", empty_n[1], u5(max_n, 1)); end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 16; i++) begin
            put(0, 8'h10 + 8'(i));
            step();
        end
        put(0, 8'hEE);
        step();
        checks++; if (u5(usedw_n, 0) !== 5'd16) begin errors++; $display("FAIL ovf_usedw got=%0d exp=16", u5(usedw_n, 0)); end
        checks++; if (fifo_stat_n[5] !== 1'b1) begin errors++; $display("FAIL ovf_bit got=%b exp=1", fifo_stat_n[5]); end
        put(0, 8'h77);
        ren = 4'b0001;
        step();
        idle();
        checks++; if (u5(usedw_n, 0) !== 5'd16) begin errors++; $display("FAIL wr_rd_full_usedw got=%0d exp=16", u5(usedw_n, 0)); end
        checks++; if (b8(rdata_n, 0) !== 8'h10) begin errors++; $display("FAIL wr_rd_full_data got=%h exp=10", b8(rdata_n, 0)); end
        ren = 4'b0001;
        step();
        checks++; if (b8(rdata_n, 0) !== 8'h11) begin errors++; $display("FAIL ovf_drain_first got=%h exp=11", b8(rdata_n, 0)); end
        for (int i = 1; i < 16; i++) step();
        idle();
        checks++; if (b8(rdata_n, 0) !== 8'h77 || empty_n[0] !== 1'b1) begin errors++; $display("FAIL ovf_drain_last got=%h empty=%b exp=77/1", b8(rdata_n, 0), empty_n[0]); end

        ren = 4'b0100;
        step();
        checks++; if (b8(fifo_stat_n, 2) !== 8'h10) begin errors++; $display("FAIL udf_set got=%h exp=10", b8(fifo_stat_n, 2)); end
        stat_clr = 4'b0100;
        step();
        checks++; if (fifo_stat_n[2*8+4] !== 1'b1) begin errors++; $display("FAIL udf_clr_race got=%b exp=1", fifo_stat_n[2*8+4]); end
        idle();
        stat_clr = 4'b0100;
        step();
        idle();
        checks++; if (b8(fifo_stat_n, 2) !== 8'h00) begin errors++; $display("FAIL udf_clr got=%h exp=00", b8(fifo_stat_n, 2)); end
        put(2, 8'h3C);
        ren = 4'b0100;
        step();
        idle();
        checks++; if (b8(fifo_stat_n, 2) !== 8'h13 || u5(usedw_n, 2) !== 5'd1) begin errors++; $display("FAIL udf_with_wr stat=%h used=%0d exp=13/1", b8(fifo_stat_n, 2), u5(usedw_n, 2)); end
        ren = 4'b0100;
        step();
        idle();
        checks++; if (b8(rdata_n, 2) !== 8'h3C) begin errors++; $display("FAIL udf_wr_data got=%h exp=3C", b8(rdata_n, 2)); end
        stat_clr = 4'b0101;
        step();
        idle();
        checks++; if (b8(fifo_stat_n, 0) !== 8'h00 || b8(fifo_stat_n, 2) !== 8'h00) begin errors++; $display("FAIL stat_clr ch0=%h ch2=%h exp 00/00", b8(fifo_stat_n, 0), b8(fifo_stat_n, 2)); end
        checks++; if (u5(max_n, 0) !== 5'd0 || u5(max_n, 2) !== 5'd0) begin errors++; $display("FAIL stat_clr_max ch0=%0d ch2=%0d exp 0/0", u5(max_n, 0), u5(max_n, 2)); end
    endtask

    task automatic test_thresholds();
        afull_thd[2*5 +: 5]  = 5'd12;
        aempty_thd[2*5 +: 5] = 5'd3;
        for (int i = 1; i <= 12; i++) begin
            put(2, 8'(i));
            step();
            if (i == 3) begin
                checks++; if (aempty_n[2] !== 1'b1) begin errors++; $display("FAIL aempty_at3 got=%b exp=1", aempty_n[2]); end
            end
            if (i == 4) begin
                checks++; if (aempty_n[2] !== 1'b0) begin errors++; $display("FAIL aempty_at4 got=%b exp=0", aempty_n[2]); end
            end
            if (i == 11) begin
                checks++; if (afull_n[2] !== 1'b0) begin errors++; $display("FAIL afull_at11 got=%b exp=0", afull_n[2]); end
            end
        end
        idle();
        checks++; if (afull_n[2] !== 1'b1 || u5(usedw_n, 2) !== 5'd12) begin errors++; $display("FAIL afull_at12 afull=%b used=%0d exp=1/12", afull_n[2], u5(usedw_n, 2)); end
        for (int i = 11; i >= 0; i--) begin
            ren = 4'b0100;
            step();
            if (i == 10) begin
                checks++; if (afull_n[2] !== 1'b1) begin errors++; $display("FAIL afull_hyst_at10 got=%b exp=1", afull_n[2]); end
            end
            if (i == 9) begin
                checks++; if (afull_n[2] !== 1'b0) begin errors++; $display("FAIL afull_clr_at9 got=%b exp=0", afull_n[2]); end
            end
        end
        idle();
        checks++; if (empty_n[2] !== 1'b1 || aempty_n[2] !== 1'b1) begin errors++; $display("FAIL thd_drained empty=%b aempty=%b exp 1/1", empty_n[2], aempty_n[2]); end
    endtask

    task automatic test_parity();
        put(3, 8'hA1); step();
        put(3, 8'hA2); step();
        put(3, 8'hA5); err_inj = 4'b1000; step();
        err_inj = '0;
        put(3, 8'hA6); step();
        idle();
        checks++; if (perr_a[3] !== 1'b0 || b8(rdata_a, 3) !== 8'hA1) begin errors++; $display("FAIL ahead_par_clean perr=%b data=%h exp 0/A1", perr_a[3], b8(rdata_a, 3)); end
        ren = 4'b1000; step();
        checks++; if (b8(rdata_n, 3) !== 8'hA1 || perr_n !== 4'h0) begin errors++; $display("FAIL par_rd1 data=%h perr=%h exp A1/0", b8(rdata_n, 3), perr_n); end
        step();
        checks++; if (b8(rdata_n, 3) !== 8'hA2 || perr_n !== 4'h0) begin errors++; $display("FAIL par_rd2 data=%h perr=%h exp A2/0", b8(rdata_n, 3), perr_n); end
        checks++; if (perr_a !== 4'b1000 || b8(rdata_a, 3) !== 8'hA5) begin errors++; $display("FAIL ahead_par_head perr=%b data=%h exp 1000/A5", perr_a, b8(rdata_a, 3)); end
        step();
        checks++; if (b8(rdata_n, 3) !== 8'hA5 || perr_n !== 4'b1000) begin errors++; $display("FAIL par_rd3 data=%h perr=%b exp A5/1000", b8(rdata_n, 3), perr_n); end
        checks++; if (fifo_stat_n[3*8+6] !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b exp=1", fifo_stat_n[3*8+6]); end
        checks++; if (perr_a[3] !== 1'b0 || b8(rdata_a, 3) !== 8'hA6) begin errors++; $display("FAIL ahead_par_next perr=%b data=%h exp 0/A6", perr_a[3], b8(rdata_a, 3)); end
        step();
        idle();
        checks++; if (b8(rdata_n, 3) !== 8'hA6 || perr_n[3] !== 1'b0) begin errors++; $display("FAIL par_pulse_end data=%h perr=%b exp A6/0", b8(rdata_n, 3), perr_n[3]); end
        checks++; if (fifo_stat_n[3*8+6] !== 1'b1 || fifo_stat_a[3*8+6] !== 1'b1) begin errors++; $display("FAIL par_sticky_hold n=%b a=%b exp 1/1", fifo_stat_n[3*8+6], fifo_stat_a[3*8+6]); end
    endtask

    task automatic test_ahead();
        put(0, 8'h55); step();
        idle();
        checks++; if (b8(rdata_a, 0) !== 8'h55) begin errors++; $display("FAIL ahead_fwft got=%h exp=55", b8(rdata_a, 0)); end
        checks++; if (b8(rdata_n, 0) !== 8'h77) begin errors++; $display("FAIL normal_hold got=%h exp=77", b8(rdata_n, 0)); end
        put(0, 8'h66);
        ren = 4'b0001;
        step();
        idle();
        checks++; if (b8(rdata_a, 0) !== 8'h66 || u5(usedw_a, 0) !== 5'd1) begin errors++; $display("FAIL ahead_pop data=%h used=%0d exp 66/1", b8(rdata_a, 0), u5(usedw_a, 0)); end
        checks++; if (b8(rdata_n, 0) !== 8'h55) begin errors++; $display("FAIL normal_pop got=%h exp=55", b8(rdata_n, 0)); end
    endtask

    task automatic test_reset_mid();
        afull_thd[1*5 +: 5] = 5'd5;
        for (int i = 0; i < 7; i++) begin
            put(1, 8'hC0 + 8'(i));
            step();
        end
        checks++; if (u5(usedw_n, 1) !== 5'd7 || afull_n[1] !== 1'b1) begin errors++; $display("FAIL pre_reset used=%0d afull=%b exp 7/1", u5(usedw_n, 1), afull_n[1]); end
        reset_n = 1'b0;
        put(1, 8'hCF);
        ren = 4'b0001;
        step();
        checks++; if (usedw_n !== 20'h0 || empty_n !== 4'hF) begin errors++; $display("FAIL mid_reset_used usedw=%h empty=%h exp 0/F", usedw_n, empty_n); end
        checks++; if (aempty_n !== 4'hF || afull_n !== 4'h0 || max_n !== 20'h0) begin errors++; $display("FAIL mid_reset_flags aempty=%h afull=%h max=%h exp F/0/0", aempty_n, afull_n, max_n); end
        checks++; if (fifo_stat_n !== 32'h0 || fifo_stat_a !== 32'h0) begin errors++; $display("FAIL mid_reset_stat n=%h a=%h exp 0", fifo_stat_n, fifo_stat_a); end
        reset_n = 1'b1;
        idle();
        step();
        checks++; if (empty_n !== 4'hF || rdata_n !== 32'h0) begin errors++; $display("FAIL post_reset empty=%h rdata=%h exp F/0", empty_n, rdata_n); end
    endtask

    initial begin
        reset_n    = 1'b0;
        afull_thd  = {4{5'd16}};
        aempty_thd = '0;
        idle();
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_thresholds();
        test_parity();
        test_ahead();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
